// File: rtl/cursor_edit_ctrl_pkg.sv
// Shared definitions for the cursor edit controller.
// Holds the FSM state encoding, group codes, bandera_cursor bit indices
// (a field index equals its bit position in bandera_cursor), the BCD
// min/max constants for each field and small lookup helpers.
package cursor_edit_ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EDIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Group codes, also the value presented on wr_group
    localparam logic [1:0] GRP_FECHA = 2'd0;
    localparam logic [1:0] GRP_HORA  = 2'd1;
    localparam logic [1:0] GRP_TIMER = 2'd2;

    localparam int unsigned NUM_FIELDS = 9;

    // Field indices == bandera_cursor bit positions
    localparam logic [3:0] FLD_DD    = 4'd8;
    localparam logic [3:0] FLD_M     = 4'd7;
    localparam logic [3:0] FLD_AN    = 4'd6;
    localparam logic [3:0] FLD_HORA  = 4'd5;
    localparam logic [3:0] FLD_MIN   = 4'd4;
    localparam logic [3:0] FLD_SEG   = 4'd3;
    localparam logic [3:0] FLD_THORA = 4'd2;
    localparam logic [3:0] FLD_TMIN  = 4'd1;
    localparam logic [3:0] FLD_TSEG  = 4'd0;

    // Field limits in packed BCD
    localparam logic [7:0] MIN_DD   = 8'h01;
    localparam logic [7:0] MAX_DD   = 8'h31;
    localparam logic [7:0] MIN_M    = 8'h01;
    localparam logic [7:0] MAX_M    = 8'h12;
    localparam logic [7:0] MIN_AN   = 8'h00;
    localparam logic [7:0] MAX_AN   = 8'h99;
    localparam logic [7:0] MIN_HORA = 8'h00;
    localparam logic [7:0] MAX_HORA = 8'h23;
    localparam logic [7:0] MIN_MS   = 8'h00;
    localparam logic [7:0] MAX_MS   = 8'h59;

    function automatic logic [7:0] field_min(input logic [3:0] fld);
        case (fld)
            FLD_DD:             field_min = MIN_DD;
            FLD_M:              field_min = MIN_M;
            FLD_AN:             field_min = MIN_AN;
            FLD_HORA, FLD_THORA: field_min = MIN_HORA;
            default:            field_min = MIN_MS;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input logic [3:0] fld);
        case (fld)
            FLD_DD:             field_max = MAX_DD;
            FLD_M:              field_max = MAX_M;
            FLD_AN:             field_max = MAX_AN;
            FLD_HORA, FLD_THORA: field_max = MAX_HORA;
            default:            field_max = MAX_MS;
        endcase
    endfunction

    // Leftmost field of a group (highest bit index within the group)
    function automatic logic [3:0] group_left(input logic [1:0] grp);
        case (grp)
            GRP_FECHA: group_left = FLD_DD;
            GRP_HORA:  group_left = FLD_HORA;
            default:   group_left = FLD_THORA;
        endcase
    endfunction

    // Rightmost field of a group (lowest bit index within the group)
    function automatic logic [3:0] group_right(input logic [1:0] grp);
        case (grp)
            GRP_FECHA: group_right = FLD_AN;
            GRP_HORA:  group_right = FLD_SEG;
            default:   group_right = FLD_TSEG;
        endcase
    endfunction

endpackage

// File: rtl/cursor_edit_ctrl_bcd_field_step.sv
// bcd_field_step: combinational one-step increment/decrement of a packed
// BCD field with wrap between min and max.
// Ports:
//   value_i  - current packed-BCD field value
//   min_i    - smallest legal value (packed BCD)
//   max_i    - largest legal value (packed BCD)
//   up_i     - 1 = increment, 0 = decrement
//   result_o - stepped value
// A value that is not BCD or lies outside [min,max] snaps to min on
// increment and to max on decrement.
module bcd_field_step (
    input  logic [7:0] value_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    input  logic       up_i,
    output logic [7:0] result_o
);

    logic [3:0] hi;
    logic [3:0] lo;
    logic       is_valid;

    assign hi = value_i[7:4];
    assign lo = value_i[3:0];

    // Valid BCD compares correctly as plain binary, so range checks can
    // use the packed value directly once both digits are known to be 0-9.
    assign is_valid = (hi <= 4'd9) && (lo <= 4'd9) &&
                      (value_i >= min_i) && (value_i <= max_i);

    always_comb begin
        result_o = value_i;
        if (!is_valid) begin
            result_o = up_i ? min_i : max_i;
        end else if (up_i) begin
            if (value_i == max_i)   result_o = min_i;
            else if (lo == 4'd9)    result_o = {hi + 4'd1, 4'd0};
            else                    result_o = {hi, lo + 4'd1};
        end else begin
            if (value_i == min_i)   result_o = max_i;
            else if (lo == 4'd0)    result_o = {hi - 4'd1, 4'd9};
            else                    result_o = {hi, lo - 4'd1};
        end
    end

endmodule

// File: rtl/cursor_edit_ctrl.sv
// cursor_edit_ctrl: on-screen editor for RTC date, time and timer fields.
// In IDLE the val_* outputs mirror the live RTC digits. btn_prog with a
// one-hot switch_cursor enters EDIT on one group; arrows move the cursor
// and step the field under it; btn_prog again requests a commit through
// a level wr_req / pulse wr_ack handshake. An idle EDIT times out back
// to IDLE without committing.
// Ports:
//   CLK, RESET            - clock, asynchronous active-high reset
//   btn_*                 - single-cycle debounced button pulses
//   switch_cursor[2:0]    - group select, one-hot (100 fecha/010 hora/001 timer)
//   digit_*[7:0]          - live packed-BCD RTC values
//   val_*[7:0]            - displayed packed-BCD values (registered)
//   bandera_cursor[8:0]   - one-hot field under edit, zero outside EDIT
//   wr_req, wr_group[1:0] - commit request level and group code
//   wr_ack                - single-cycle commit acknowledge
//   state_dbg_o[1:0]      - current FSM state
// Handshake: wr_req rises on entry to COMMIT and stays high, with wr_group
// stable, until the cycle after wr_ack is sampled high in COMMIT; wr_ack in
// any other state has no effect.
module cursor_edit_ctrl
    import cursor_edit_ctrl_pkg::*;
#(
    parameter int unsigned EDIT_TIMEOUT = 250000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       btn_prog,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [2:0] switch_cursor,
    input  logic [7:0] digit_DD,
    input  logic [7:0] digit_M,
    input  logic [7:0] digit_AN,
    input  logic [7:0] digit_HORA,
    input  logic [7:0] digit_MIN,
    input  logic [7:0] digit_SEG,
    input  logic [7:0] digit_TimerHORA,
    input  logic [7:0] digit_TimerMIN,
    input  logic [7:0] digit_TimerSEG,
    output logic [7:0] val_DD,
    output logic [7:0] val_M,
    output logic [7:0] val_AN,
    output logic [7:0] val_HORA,
    output logic [7:0] val_MIN,
    output logic [7:0] val_SEG,
    output logic [7:0] val_TimerHORA,
    output logic [7:0] val_TimerMIN,
    output logic [7:0] val_TimerSEG,
    output logic [8:0] bandera_cursor,
    output logic       wr_req,
    output logic [1:0] wr_group,
    input  logic       wr_ack,
    output logic [1:0] state_dbg_o
);

    localparam int unsigned CNT_W = (EDIT_TIMEOUT > 2) ? $clog2(EDIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EDIT_TIMEOUT - 1);

    logic [1:0]                 state_q,    state_d;
    logic [1:0]                 group_q,    group_d;
    logic [3:0]                 cursor_q,   cursor_d;
    logic [NUM_FIELDS-1:0][7:0] val_q,      val_d;
    logic [8:0]                 bandera_q,  bandera_d;
    logic                       wr_req_q,   wr_req_d;
    logic [1:0]                 wr_group_q, wr_group_d;
    logic [CNT_W-1:0]           cnt_q,      cnt_d;

    logic [NUM_FIELDS-1:0][7:0] digit_vec;
    logic                       any_btn;
    logic                       sel_valid;
    logic [1:0]                 sel_group;
    logic [7:0]                 step_out;

    // Index 8 (DD) is the MSB slice, matching the bandera_cursor bit order
    assign digit_vec = {digit_DD, digit_M, digit_AN, digit_HORA, digit_MIN,
                        digit_SEG, digit_TimerHORA, digit_TimerMIN, digit_TimerSEG};

    assign any_btn = btn_prog | btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        sel_valid = 1'b1;
        sel_group = GRP_FECHA;
        case (switch_cursor)
            3'b100:  sel_group = GRP_FECHA;
            3'b010:  sel_group = GRP_HORA;
            3'b001:  sel_group = GRP_TIMER;
            default: sel_valid = 1'b0;
        endcase
    end

    // Single stepper shared by all fields through the cursor mux
    bcd_field_step u_step (
        .value_i  (val_q[cursor_q]),
        .min_i    (field_min(cursor_q)),
        .max_i    (field_max(cursor_q)),
        .up_i     (btn_up),
        .result_o (step_out)
    );

    always_comb begin
        state_d    = state_q;
        group_d    = group_q;
        cursor_d   = cursor_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        wr_group_d = wr_group_q;

        case (state_q)
            ST_IDLE: begin
                val_d = digit_vec;
                cnt_d = '0;
                if (btn_prog && sel_valid) begin
                    state_d  = ST_EDIT;
                    group_d  = sel_group;
                    cursor_d = group_left(sel_group);
                end
            end

            ST_EDIT: begin
                if (btn_prog) begin
                    // prog wins over any arrow pressed in the same cycle
                    state_d    = ST_COMMIT;
                    wr_group_d = group_q;
                    cnt_d      = '0;
                end else begin
                    if (btn_up ^ btn_down)
                        val_d[cursor_q] = step_out;
                    // Field indices decrease left to right
                    if (btn_right && !btn_left)
                        cursor_d = (cursor_q == group_right(group_q)) ?
                                   group_left(group_q) : cursor_q - 4'd1;
                    if (btn_left && !btn_right)
                        cursor_d = (cursor_q == group_left(group_q)) ?
                                   group_right(group_q) : cursor_q + 4'd1;
                    if (any_btn) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_COMMIT: begin
                if (wr_ack)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        bandera_d = '0;
        if (state_d == ST_EDIT)
            bandera_d[cursor_d] = 1'b1;
        wr_req_d = (state_d == ST_COMMIT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            group_q    <= GRP_FECHA;
            cursor_q   <= FLD_DD;
            val_q      <= '0;
            bandera_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_group_q <= GRP_FECHA;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            group_q    <= group_d;
            cursor_q   <= cursor_d;
            val_q      <= val_d;
            bandera_q  <= bandera_d;
            wr_req_q   <= wr_req_d;
            wr_group_q <= wr_group_d;
            cnt_q      <= cnt_d;
        end
    end

    assign val_DD         = val_q[FLD_DD];
    assign val_M          = val_q[FLD_M];
    assign val_AN         = val_q[FLD_AN];
    assign val_HORA       = val_q[FLD_HORA];
    assign val_MIN        = val_q[FLD_MIN];
    assign val_SEG        = val_q[FLD_SEG];
    assign val_TimerHORA  = val_q[FLD_THORA];
    assign val_TimerMIN   = val_q[FLD_TMIN];
    assign val_TimerSEG   = val_q[FLD_TSEG];
    assign bandera_cursor = bandera_q;
    assign wr_req         = wr_req_q;
    assign wr_group       = wr_group_q;
    assign state_dbg_o    = state_q;

endmodule
